rram_access_seq: RTL and testbench

Parametrised access sequencer for a ROWS x COLS 1T1R RRAM crossbar in the user analog area. It turns single-cell READ/SET/RESET commands into timed word-line/bit-line pulses and samples the asynchronous source-line outputs through a synchroniser. Writes are followed by a verify read with bounded retry. Command and response handshakes face the Wishbone/LA control logic; `wl`/`bl`/`pol`/`rd_en` drive the array wrapper directly.

---
 rtl/rram_access_seq_if.sv | 41 ++++
 rtl/rram_access_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_rram_access_seq.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rram_access_seq_if.sv
// Command/response handshake bundle between the control logic (master)
// and the RRAM access sequencer (slave).
interface rram_access_seq_if #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int CNT_W = 8
);
    localparam int AW_R = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW_C = (COLS > 1) ? $clog2(COLS) : 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [AW_R-1:0]  cmd_row;
    logic [AW_C-1:0]  cmd_col;
    logic [CNT_W-1:0] cfg_pulse;
    logic [CNT_W-1:0] cfg_settle;
    logic [3:0]       cfg_retry;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_data;
    logic             rsp_err;
    logic [3:0]       rsp_retries;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_col,
        output cfg_pulse, cfg_settle, cfg_retry,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_err, rsp_retries
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_col,
        input  cfg_pulse, cfg_settle, cfg_retry,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_err, rsp_retries
    );
endinterface

// File: rtl/rram_access_seq.sv
// Single-cell access sequencer for a ROWS x COLS 1T1R RRAM crossbar.
// Turns READ/SET/RESET commands into timed word-line/bit-line pulses,
// samples the source lines through a 2-flop synchroniser and performs a
// verify read with bounded retry after every programming pulse.
// The interface instance must be built with the same ROWS/COLS/CNT_W.
module rram_access_seq #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    rram_access_seq_if.slave bus,
    input  logic [COLS-1:0]  sl,
    output logic [ROWS-1:0]  wl,
    output logic [COLS-1:0]  bl,
    output logic             pol,
    output logic             rd_en,
    output logic             busy
);
    localparam int AW_R = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW_C = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [AW_R:0]  ROWS_L  = ROWS[AW_R:0];
    localparam logic [AW_C:0]  COLS_L  = COLS[AW_C:0];
    localparam logic [CNT_W:0] CNT_ONE = 1;
    localparam logic [ROWS-1:0] ROW_ONE = 1;
    localparam logic [COLS-1:0] COL_ONE = 1;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        GAP,
        SENSE,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_SET   = 2'b01,
        OP_RESET = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [AW_R-1:0]  row_q, row_d;
    logic [AW_C-1:0]  col_q, col_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [3:0]       retry_lim_q, retry_lim_d;
    logic [3:0]       retries_q, retries_d;
    logic [CNT_W:0]   cnt_q, cnt_d;
    logic             retry_gap_q, retry_gap_d;
    logic             rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ROWS-1:0]  wl_q, wl_d;
    logic [COLS-1:0]  bl_q, bl_d;
    logic             pol_q, pol_d;
    logic             rd_en_q, rd_en_d;
    logic [COLS-1:0]  sync1_q, sync1_d;
    logic [COLS-1:0]  sync2_q, sync2_d;

    logic             cmd_bad;
    logic             sensed;
    logic             want;
    logic             lines_on;

    // Counter load for a pulse of max(p,1) cycles (counts down to zero).
    function automatic logic [CNT_W:0] pulse_load(input logic [CNT_W-1:0] p);
        return (p == '0) ? '0 : ({1'b0, p} - CNT_ONE);
    endfunction

    // Counter load for a sense window of s+2 cycles.
    function automatic logic [CNT_W:0] settle_load(input logic [CNT_W-1:0] s);
        return {1'b0, s} + CNT_ONE;
    endfunction

    assign cmd_bad = (bus.cmd_op == OP_RSVD) ||
                     ({1'b0, bus.cmd_row} >= ROWS_L) ||
                     ({1'b0, bus.cmd_col} >= COLS_L);

    assign sensed = sync2_q[col_q];
    assign want   = (op_q == OP_SET);

    // Next-state, command latching, verify decision and registered line drive.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        row_d       = row_q;
        col_d       = col_q;
        pulse_d     = pulse_q;
        settle_d    = settle_q;
        retry_lim_d = retry_lim_q;
        retries_d   = retries_q;
        cnt_d       = cnt_q;
        retry_gap_d = retry_gap_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        sync1_d     = sl;
        sync2_d     = sync1_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d        = op_t'(bus.cmd_op);
                    row_d       = bus.cmd_row;
                    col_d       = bus.cmd_col;
                    pulse_d     = bus.cfg_pulse;
                    settle_d    = bus.cfg_settle;
                    retry_lim_d = bus.cfg_retry;
                    retries_d   = '0;
                    retry_gap_d = 1'b0;
                    rsp_data_d  = 1'b0;
                    rsp_err_d   = 1'b0;
                    if (cmd_bad) begin
                        state_d   = RESP;
                        rsp_err_d = 1'b1;
                    end else if (op_t'(bus.cmd_op) == OP_READ) begin
                        state_d = SENSE;
                        cnt_d   = settle_load(bus.cfg_settle);
                    end else begin
                        state_d = PULSE;
                        cnt_d   = pulse_load(bus.cfg_pulse);
                    end
                end
            end

            PULSE: begin
                if (cnt_q == '0) begin
                    state_d     = GAP;
                    retry_gap_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            // The same GAP state separates pulse->sense and sense->re-pulse;
            // retry_gap_q remembers which direction we are heading.
            GAP: begin
                if (retry_gap_q) begin
                    state_d = PULSE;
                    cnt_d   = pulse_load(pulse_q);
                end else begin
                    state_d = SENSE;
                    cnt_d   = settle_load(settle_q);
                end
            end

            SENSE: begin
                if (cnt_q == '0) begin
                    rsp_data_d = sensed;
                    if (op_q == OP_READ || sensed == want) begin
                        state_d = RESP;
                    end else if (retries_q < retry_lim_q) begin
                        retries_d   = retries_q + 4'd1;
                        retry_gap_d = 1'b1;
                        state_d     = GAP;
                    end else begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Line drive follows the state being entered so it is registered
        // alongside the state and lines up with it cycle for cycle.
        lines_on    = (state_d == PULSE) || (state_d == SENSE);
        wl_d        = lines_on ? (ROW_ONE << row_d) : '0;
        bl_d        = lines_on ? (COL_ONE << col_d) : '0;
        pol_d       = (state_d == PULSE) && (op_d == OP_RESET);
        rd_en_d     = (state_d == SENSE);
        rsp_valid_d = (state_d == RESP);
    end

    // State, latched command, synchroniser and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_READ;
            row_q       <= '0;
            col_q       <= '0;
            pulse_q     <= '0;
            settle_q    <= '0;
            retry_lim_q <= '0;
            retries_q   <= '0;
            cnt_q       <= '0;
            retry_gap_q <= 1'b0;
            rsp_data_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            wl_q        <= '0;
            bl_q        <= '0;
            pol_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            row_q       <= row_d;
            col_q       <= col_d;
            pulse_q     <= pulse_d;
            settle_q    <= settle_d;
            retry_lim_q <= retry_lim_d;
            retries_q   <= retries_d;
            cnt_q       <= cnt_d;
            retry_gap_q <= retry_gap_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            wl_q        <= wl_d;
            bl_q        <= bl_d;
            pol_q       <= pol_d;
            rd_en_q     <= rd_en_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
        end
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_retries = retries_q;
    assign busy            = (state_q != IDLE);
    assign wl              = wl_q;
    assign bl              = bl_q;
    assign pol             = pol_q;
    assign rd_en           = rd_en_q;

    // Array safety: never more than one word line / bit line, and the
    // RESET polarity only while sensing is off.
    a_wl_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(wl_q));
    a_bl_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(bl_q));
    a_pol_sense: assert property (@(posedge clk) disable iff (reset) !(pol_q && rd_en_q));
endmodule

// File: tb/tb_rram_access_seq.sv
// Scoreboard bench for rram_access_seq (ROWS=18, COLS=16, CNT_W=8).
// The driver pushes the hand-computed response and line profile of each
// command; an independent monitor tracks the lines and pops/compares on
// every response handshake.
module tb_rram_access_seq;
    localparam int ROWS  = 18;
    localparam int COLS  = 16;
    localparam int CNT_W = 8;

    typedef struct {
        string       name;
        int          acc;
        int          lat;
        int          data;
        int          err;
        int          ret;
        int          pc;
        int          polc;
        int          sc;
        int          st;
        int          fp;
        int          fs;
        logic [17:0] ewl;
        logic [15:0] ebl;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [COLS-1:0] sl;
    logic [ROWS-1:0] wl;
    logic [COLS-1:0] bl;
    logic            pol;
    logic            rd_en;
    logic            busy;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int spurious   = 0;

    exp_t q[$];

    rram_access_seq_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) bus ();

    rram_access_seq #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .sl    (sl),
        .wl    (wl),
        .bl    (bl),
        .pol   (pol),
        .rd_en (rd_en),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    function automatic void chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    function automatic exp_t mk(input string nm, input int lat, input int d, input int e,
                                input int r, input int pc, input int polc, input int sc,
                                input int st, input int fp, input int fs);
        exp_t x;
        x.name = nm; x.acc = 0; x.lat = lat; x.data = d; x.err = e; x.ret = r;
        x.pc = pc; x.polc = polc; x.sc = sc; x.st = st; x.fp = fp; x.fs = fs;
        x.ewl = '0; x.ebl = '0;
        return x;
    endfunction

    // ---------------- monitor ----------------
    int   m_pc, m_polc, m_sc, m_st, m_fp, m_fs, m_rise, m_k;
    bit   m_bad, m_seen, m_prev_pulse, m_pulse_now;
    logic m_hd, m_he;
    logic [3:0] m_hr;

    initial begin
        m_pc = 0; m_polc = 0; m_sc = 0; m_st = 0; m_fp = 0; m_fs = 0; m_rise = 0;
        m_bad = 0; m_seen = 0; m_prev_pulse = 0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.cmd_ready == busy) m_bad = 1;
            if (q.size() == 0) begin
                if (bus.rsp_valid) spurious++;
            end else begin
                m_k = cyc - q[0].acc;
                if (m_k >= 1) begin
                    m_pulse_now = (wl != '0) && !rd_en;
                    if ((wl != '0 || bl != '0) && (wl != q[0].ewl || bl != q[0].ebl)) m_bad = 1;
                    if (pol && !m_pulse_now) m_bad = 1;
                    if (rd_en && wl == '0) m_bad = 1;
                    if (bus.cmd_ready) m_bad = 1;
                    if (m_pulse_now) m_pc++;
                    if (pol) m_polc++;
                    if (rd_en) begin
                        m_sc++;
                        if (m_fs == 0) m_fs = m_k;
                    end
                    if (m_pulse_now && !m_prev_pulse) begin
                        m_st++;
                        if (m_fp == 0) m_fp = m_k;
                    end
                    m_prev_pulse = m_pulse_now;
                end
                if (bus.rsp_valid) begin
                    if (!m_seen) begin
                        m_seen = 1;
                        m_rise = m_k;
                        m_hd = bus.rsp_data; m_he = bus.rsp_err; m_hr = bus.rsp_retries;
                    end else if (bus.rsp_data !== m_hd || bus.rsp_err !== m_he ||
                                 bus.rsp_retries !== m_hr) begin
                        m_bad = 1;
                    end
                    if (bus.rsp_ready) begin
                        if (q[0].lat >= 0) chk({q[0].name, "_latency"}, m_rise, q[0].lat);
                        chk({q[0].name, "_data"},        int'(bus.rsp_data),    q[0].data);
                        chk({q[0].name, "_err"},         int'(bus.rsp_err),     q[0].err);
                        chk({q[0].name, "_retries"},     int'(bus.rsp_retries), q[0].ret);
                        chk({q[0].name, "_pulse_cyc"},   m_pc,   q[0].pc);
                        chk({q[0].name, "_pol_cyc"},     m_polc, q[0].polc);
                        chk({q[0].name, "_sense_cyc"},   m_sc,   q[0].sc);
                        chk({q[0].name, "_pulses"},      m_st,   q[0].st);
                        chk({q[0].name, "_first_pulse"}, m_fp,   q[0].fp);
                        chk({q[0].name, "_first_sense"}, m_fs,   q[0].fs);
                        chk({q[0].name, "_protocol"},    int'(m_bad), 0);
                        void'(q.pop_front());
                        m_pc = 0; m_polc = 0; m_sc = 0; m_st = 0; m_fp = 0; m_fs = 0;
                        m_bad = 0; m_seen = 0; m_prev_pulse = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [1:0] op, input int row, input int col, input int p,
                         input int s, input int r, input bit push, input exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({e.name, "_cmd_ready"}, int'(bus.cmd_ready), 1);
        bus.cmd_op     = op;
        bus.cmd_row    = row[4:0];
        bus.cmd_col    = col[3:0];
        bus.cfg_pulse  = p[7:0];
        bus.cfg_settle = s[7:0];
        bus.cfg_retry  = r[3:0];
        bus.cmd_valid  = 1'b1;
        e.acc = cyc;
        e.ewl = '0;
        if (row < ROWS) e.ewl[row] = 1'b1;
        e.ebl = '0;
        if (col < COLS) e.ebl[col] = 1'b1;
        if (push) q.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_pending_after_timeout", q.size(), 0);
        q.delete();
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_wl"},          int'(wl), 0);
        chk({tag, "_bl"},          int'(bl), 0);
        chk({tag, "_pol"},         int'(pol), 0);
        chk({tag, "_rd_en"},       int'(rd_en), 0);
        chk({tag, "_rsp_valid"},   int'(bus.rsp_valid), 0);
        chk({tag, "_rsp_data"},    int'(bus.rsp_data), 0);
        chk({tag, "_rsp_err"},     int'(bus.rsp_err), 0);
        chk({tag, "_rsp_retries"}, int'(bus.rsp_retries), 0);
        chk({tag, "_busy"},        int'(busy), 0);
        chk({tag, "_cmd_ready"},   int'(bus.cmd_ready), 1);
    endtask

    initial begin
        reset          = 1'b1;
        sl             = '0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_row    = '0;
        bus.cmd_col    = '0;
        bus.cfg_pulse  = '0;
        bus.cfg_settle = '0;
        bus.cfg_retry  = '0;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check_rst("init");
        reset = 1'b0;

        // SET, sl already 1: pulse 1-4, gap 5, sense 6-9, response at 10.
        // cfg_* changed after accept must not affect the command.
        sl = 16'h0020;
        issue(2'b01, 3, 5, 4, 2, 0, 1'b1, mk("set_r3c5", 10, 1, 0, 0, 4, 0, 4, 1, 1, 6));
        bus.cfg_pulse = 8'd9; bus.cfg_settle = 8'd7; bus.cfg_retry = 4'd5;
        wait_done();

        // RESET with sl stuck at 1: three 2-cycle pulses, retries exhausted.
        sl = 16'h8000;
        issue(2'b10, 0, 15, 2, 1, 2, 1'b1, mk("reset_stuck", -1, 1, 1, 2, 6, 6, 9, 3, 1, 4));
        wait_done();

        // RESET that succeeds on the second verify (sl drops after first sense).
        sl = 16'h0002;
        issue(2'b10, 2, 1, 1, 0, 3, 1'b1, mk("reset_retry1", -1, 0, 0, 1, 2, 2, 4, 2, 1, 3));
        repeat (4) @(negedge clk);
        sl = 16'h0000;
        wait_done();

        // READ with response back-pressure for 5 cycles.
        bus.rsp_ready = 1'b0;
        sl = 16'h0080;
        issue(2'b00, 4, 7, 5, 0, 0, 1'b1, mk("read_c7_stall", 3, 1, 0, 0, 0, 0, 2, 0, 0, 1));
        repeat (7) @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_done();

        // Reserved opcode and out-of-range row: immediate error, no lines.
        sl = 16'hFFFF;
        issue(2'b11, 1, 1, 3, 3, 1, 1'b1, mk("op_rsvd", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        wait_done();
        issue(2'b01, 20, 3, 3, 3, 1, 1'b1, mk("row20", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        wait_done();

        // Top row, cfg_pulse=0 behaves as a 1-cycle pulse.
        sl = 16'h0001;
        issue(2'b01, 17, 0, 0, 0, 0, 1'b1, mk("set_r17_p0", 5, 1, 0, 0, 1, 0, 2, 1, 1, 3));
        wait_done();

        // Reset asserted during the 2nd PULSE cycle: no response, then a READ.
        sl = 16'h0004;
        issue(2'b01, 1, 2, 4, 1, 0, 1'b0, mk("aborted", -1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_rst("midreset");
        reset = 1'b0;
        repeat (12) @(negedge clk);
        sl = 16'h0200;
        issue(2'b00, 5, 9, 2, 3, 0, 1'b1, mk("read_after_rst", 6, 1, 0, 0, 0, 0, 5, 0, 0, 1));
        wait_done();

        repeat (4) @(negedge clk);
        chk("no_spurious_rsp", spurious, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
